// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared encodings for the pipeline hazard controller
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/forward_select_unit.sv
// forward_select_unit: picks the freshest forwardable source for one EX operand
module forward_select_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] addr,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_rd_write_enable,
    input  logic       mem_rd_select,
    input  logic [4:0] wb_rd_addr,
    input  logic       wb_rd_write_enable,
    output logic [1:0] sel
);
    logic mem_hit, wb_hit;

    // load data in MEM is not ready yet, so only ALU results forward from MEM
    always_comb begin
        mem_hit = mem_rd_write_enable && !mem_rd_select && mem_rd_addr != REG_ZERO && mem_rd_addr == addr;
        wb_hit  = wb_rd_write_enable && wb_rd_addr != REG_ZERO && wb_rd_addr == addr;
        sel     = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencing, divide hold, forwarding selects
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_branch_taken,
    input  logic [4:0]  ex_rs_addr,
    input  logic [4:0]  ex_rt_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rd_write_enable,
    input  logic        ex_dmem_read,
    input  logic        ex_div_start,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_rd_write_enable,
    input  logic        mem_rd_select,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_rd_write_enable,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        div_busy,
    output logic        div_done,
    output logic [1:0]  forward_a_sel,
    output logic [1:0]  forward_b_sel,
    output logic [31:0] stall_cycles
);
    div_state_t       state;
    logic [CNT_W-1:0] div_count;
    logic             div_stall, load_use;

    // the starting cycle already stalls, so the busy phase covers DIV_LATENCY-1 more
    always_comb begin
        div_stall    = (state == IDLE && ex_div_start) || state == DIV_BUSY;
        load_use     = ex_dmem_read && ex_rd_write_enable && ex_rd_addr != REG_ZERO &&
                       ((id_uses_rs && id_rs_addr == ex_rd_addr) || (id_uses_rt && id_rt_addr == ex_rd_addr));
        pc_stall     = div_stall || load_use;
        if_id_stall  = div_stall || load_use;
        id_ex_stall  = div_stall;
        ex_mem_flush = div_stall;
        id_ex_flush  = load_use && !div_stall;
        if_id_flush  = id_branch_taken && !load_use && !div_stall;
        div_busy     = div_stall;
        div_done     = state == DIV_DONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div_count    <= '0;
            stall_cycles <= '0;
        end else begin
            if (pc_stall)
                stall_cycles <= stall_cycles + 32'd1;
            case (state)
                IDLE: if (ex_div_start) begin
                    state     <= DIV_BUSY;
                    div_count <= CNT_W'(DIV_LATENCY - 1);
                end
                DIV_BUSY: begin
                    div_count <= div_count - CNT_W'(1);
                    if (div_count == CNT_W'(1))
                        state <= DIV_DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    forward_select_unit u_fwd_a (
        .addr                (ex_rs_addr),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_write_enable (mem_rd_write_enable),
        .mem_rd_select       (mem_rd_select),
        .wb_rd_addr          (wb_rd_addr),
        .wb_rd_write_enable  (wb_rd_write_enable),
        .sel                 (forward_a_sel)
    );

    forward_select_unit u_fwd_b (
        .addr                (ex_rt_addr),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_write_enable (mem_rd_write_enable),
        .mem_rd_select       (mem_rd_select),
        .wb_rd_addr          (wb_rd_addr),
        .wb_rd_write_enable  (wb_rd_write_enable),
        .sel                 (forward_b_sel)
    );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and random checks against a cycle-count reference model
module tb_pipeline_hazard_controller;
    localparam int L = 4;

    logic        clock = 1'b0, reset;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic        id_uses_rs, id_uses_rt, id_branch_taken, ex_rd_write_enable, ex_dmem_read, ex_div_start;
    logic        mem_rd_write_enable, mem_rd_select, wb_rd_write_enable;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, div_busy, div_done;
    logic [1:0]  forward_a_sel, forward_b_sel;
    logic [31:0] stall_cycles;

    int          tests = 0, fails = 0;
    int          m_left;
    bit          m_done;
    logic [31:0] m_cnt;

    pipeline_hazard_controller #(.DIV_LATENCY(L), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_rd_addr(ex_rd_addr), .ex_rd_write_enable(ex_rd_write_enable), .ex_dmem_read(ex_dmem_read),
        .ex_div_start(ex_div_start), .mem_rd_addr(mem_rd_addr), .mem_rd_write_enable(mem_rd_write_enable),
        .mem_rd_select(mem_rd_select), .wb_rd_addr(wb_rd_addr), .wb_rd_write_enable(wb_rd_write_enable),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .div_busy(div_busy), .div_done(div_done),
        .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd(logic [4:0] a);
        if (mem_rd_write_enable && !mem_rd_select && mem_rd_addr != 0 && mem_rd_addr == a) return 2'b10;
        if (wb_rd_write_enable && wb_rd_addr != 0 && wb_rd_addr == a) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr} = '0;
        {id_uses_rs, id_uses_rt, id_branch_taken, ex_rd_write_enable, ex_dmem_read, ex_div_start} = '0;
        {mem_rd_write_enable, mem_rd_select, wb_rd_write_enable} = '0;
    endtask

    task automatic model_reset();
        m_left = 0;
        m_done = 0;
        m_cnt  = '0;
    endtask

    // inputs are set at a falling edge; check this cycle, then advance the model across the rising edge
    task automatic step();
        bit idle, ds, lu, ps;
        #1;
        idle = m_left == 0 && !m_done;
        ds   = m_left > 0 || (idle && ex_div_start);
        lu   = ex_dmem_read && ex_rd_write_enable && ex_rd_addr != 0 &&
               ((id_uses_rs && id_rs_addr == ex_rd_addr) || (id_uses_rt && id_rt_addr == ex_rd_addr));
        ps   = ds || lu;
        check("pc_stall", pc_stall, ps);
        check("if_id_stall", if_id_stall, ps);
        check("id_ex_stall", id_ex_stall, ds);
        check("ex_mem_flush", ex_mem_flush, ds);
        check("id_ex_flush", id_ex_flush, lu && !ds);
        check("if_id_flush", if_id_flush, id_branch_taken && !ps);
        check("div_busy", div_busy, ds);
        check("div_done", div_done, m_done);
        check("forward_a_sel", forward_a_sel, fwd(ex_rs_addr));
        check("forward_b_sel", forward_b_sel, fwd(ex_rt_addr));
        check("stall_cycles", stall_cycles, m_cnt);
        @(posedge clock);
        if (!reset) begin
            if (ds) begin
                m_left = (m_left > 0 ? m_left : L) - 1;
                m_done = m_left == 0;
            end else m_done = 0;
            if (ps) m_cnt++;
        end
        @(negedge clock);
    endtask

    task automatic run_div(string tag);
        int busy_seen = 0, done_at = -1;
        ex_div_start = 1'b1;
        for (int i = 0; i <= L; i++) begin
            #1;
            busy_seen += int'(div_busy);
            if (div_done) done_at = i;
            step();
        end
        ex_div_start = 1'b0;
        check({tag, "_busy_cycles"}, busy_seen, L);
        check({tag, "_done_cycle"}, done_at, L);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        step();
        reset = 1'b0;
        check("reset_stall_cycles", stall_cycles, 0);

        run_div("div");
        check("div_stall_cycles", stall_cycles, L);
        step();

        ex_dmem_read = 1; ex_rd_write_enable = 1; ex_rd_addr = 8; id_uses_rs = 1; id_rs_addr = 8;
        #1 check("load_use_flush", id_ex_flush, 1);
        step();
        ex_dmem_read = 0;
        #1 check("load_use_release", pc_stall, 0);
        step();
        ex_dmem_read = 1; ex_rd_addr = 0; id_rs_addr = 0;
        #1 check("load_r0_no_stall", pc_stall, 0);
        step();

        ex_rd_addr = 8; id_rs_addr = 8; id_branch_taken = 1;
        #1 check("branch_suppressed", if_id_flush, 0);
        step();
        ex_dmem_read = 0;
        #1 check("branch_retry", if_id_flush, 1);
        step();
        clear_inputs();

        mem_rd_addr = 5; wb_rd_addr = 5; ex_rs_addr = 5; mem_rd_write_enable = 1; wb_rd_write_enable = 1;
        #1 check("fwd_mem_priority", forward_a_sel, 2'b10);
        step();
        mem_rd_select = 1;
        #1 check("fwd_load_to_wb", forward_a_sel, 2'b01);
        step();
        clear_inputs();

        ex_div_start = 1;
        step();
        step();
        #1 check("div_busy_before_reset", div_busy, 1);
        reset = 1; ex_div_start = 0;
        model_reset();
        #1 check("reset_mid_div_busy", div_busy, 0);
        step();
        reset = 0;
        check("reset_mid_div_count", stall_cycles, 0);
        run_div("div_after_reset");
        step();

        force dut.stall_cycles = 32'hFFFF_FFFF;
        #1 release dut.stall_cycles;
        m_cnt = 32'hFFFF_FFFF;
        ex_dmem_read = 1; ex_rd_write_enable = 1; ex_rd_addr = 3; id_uses_rt = 1; id_rt_addr = 3;
        step();
        clear_inputs();
        #1 check("stall_wrap", stall_cycles, 0);
        step();

        for (int i = 0; i < 400; i++) begin
            id_rs_addr = 5'($urandom_range(0, 3));
            id_rt_addr = 5'($urandom_range(0, 3));
            ex_rs_addr = 5'($urandom_range(0, 3));
            ex_rt_addr = 5'($urandom_range(0, 3));
            ex_rd_addr = 5'($urandom_range(0, 3));
            mem_rd_addr = 5'($urandom_range(0, 3));
            wb_rd_addr = 5'($urandom_range(0, 3));
            {id_uses_rs, id_uses_rt, id_branch_taken, ex_rd_write_enable} = 4'($urandom);
            {mem_rd_write_enable, mem_rd_select, wb_rd_write_enable} = 3'($urandom);
            ex_dmem_read = 1'($urandom);
            ex_div_start = $urandom_range(0, 15) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
